redutor_sinal: RTL and testbench



---
 rtl/redutor_pkg.sv | 16 +
 rtl/redutor_sinal_fila_2.sv | 56 +++++
 rtl/redutor_sinal.sv | 105 ++++++++++
 tb/tb_redutor_sinal.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/redutor_pkg.sv
// Shared constants and types for the 32->16 signed narrowing path (redutor_sinal).
package redutor_pkg;

    localparam int LARG_ENTRADA_PADRAO  = 32;
    localparam int LARG_SAIDA_PADRAO    = 16;
    localparam int LARG_CONTADOR_PADRAO = 8;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

    typedef struct packed {
        logic [LARG_SAIDA_PADRAO-1:0] palavra;
        logic                         estouro;
    } entrada_fila_t;

endpackage

// File: rtl/redutor_sinal_fila_2.sv
// fila_2: two-entry synchronous FIFO, generic in entry width; output reads as zero when empty.
module fila_2 #(
    parameter int LARGURA = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [LARGURA-1:0] i_dado,
    output logic [LARGURA-1:0] o_dado,
    output logic               o_cheia,
    output logic               o_vazia
);

    logic [LARGURA-1:0] r_mem [2];
    logic               r_rd;
    logic               r_wr;
    logic [1:0]         r_nivel;
    logic               w_push_ok;
    logic               w_pop_ok;

    // A push into a full FIFO is dropped even when a pop happens in the same cycle.
    assign w_push_ok = i_push & (r_nivel != 2'd2);
    assign w_pop_ok  = i_pop & (r_nivel != 2'd0);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr] <= i_dado;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_nivel <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_wr <= ~r_wr;
            end
            if (w_pop_ok) begin
                r_rd <= ~r_rd;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_nivel <= r_nivel + 2'd1;
                2'b01:   r_nivel <= r_nivel - 2'd1;
                default: r_nivel <= r_nivel;
            endcase
        end
    end

    assign o_cheia = (r_nivel == 2'd2);
    assign o_vazia = (r_nivel == 2'd0);
    assign o_dado  = o_vazia ? '0 : r_mem[r_rd];

endmodule

// File: rtl/redutor_sinal.sv
// redutor_sinal: narrows signed words to a smaller width with per-word saturate/wrap, 2-entry stream buffer.
// Optional overflow counter port enabled by defining REDUTOR_CONTADOR_EN.
module redutor_sinal
    import redutor_pkg::*;
#(
    parameter int LARGURA_ENTRADA  = LARG_ENTRADA_PADRAO,
    parameter int LARGURA_SAIDA    = LARG_SAIDA_PADRAO,
    parameter int LARGURA_CONTADOR = LARG_CONTADOR_PADRAO
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        entrada_valida,
    output logic                        entrada_pronta,
    input  logic [LARGURA_ENTRADA-1:0]  palavra_entrada,
    input  logic                        modo_saturar,
    output logic                        saida_valida,
    input  logic                        saida_pronta,
    output logic [LARGURA_SAIDA-1:0]    palavra_saida,
    output logic                        saida_estourou,
    output logic                        estouro_sticky,
    input  logic                        limpar_status
`ifdef REDUTOR_CONTADOR_EN
    ,
    output logic [LARGURA_CONTADOR-1:0] contador_estouro
`endif
);

    localparam int LARGURA_TOPO = LARGURA_ENTRADA - LARGURA_SAIDA + 1;

    function automatic logic [LARGURA_SAIDA-1:0] saturar(input logic negativo);
        return negativo ? {1'b1, {(LARGURA_SAIDA-1){1'b0}}}
                        : {1'b0, {(LARGURA_SAIDA-1){1'b1}}};
    endfunction

    logic signed [LARGURA_ENTRADA-1:0] w_palavra_s;
    logic [LARGURA_TOPO-1:0]           w_topo;
    logic                              w_estouro;
    logic [LARGURA_SAIDA-1:0]          w_resultado;
    logic                              w_push;
    logic                              w_pop;
    logic                              w_cheia;
    logic                              w_vazia;
    logic [LARGURA_SAIDA:0]            w_cabeca;
    logic                              r_sticky;

    assign w_palavra_s = palavra_entrada;
    assign w_topo      = palavra_entrada[LARGURA_ENTRADA-1:LARGURA_SAIDA-1];

    // The word fits only when the dropped bits are copies of the new sign bit.
    assign w_estouro   = ~((&w_topo) | ~(|w_topo));
    assign w_resultado = (w_estouro && modo_saturar)
                       ? saturar(w_palavra_s[LARGURA_ENTRADA-1])
                       : palavra_entrada[LARGURA_SAIDA-1:0];

    assign w_push = entrada_valida & entrada_pronta;
    assign w_pop  = saida_valida & saida_pronta;

    fila_2 #(
        .LARGURA (LARGURA_SAIDA + 1)
    ) u_fila (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_dado  ({w_resultado, w_estouro}),
        .o_dado  (w_cabeca),
        .o_cheia (w_cheia),
        .o_vazia (w_vazia)
    );

    assign entrada_pronta = ~w_cheia;
    assign saida_valida   = ~w_vazia;
    assign palavra_saida  = w_cabeca[LARGURA_SAIDA:1];
    assign saida_estourou = w_cabeca[0];

    // Set has priority over clear so an overflow in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (w_push && w_estouro) begin
            r_sticky <= 1'b1;
        end else if (limpar_status) begin
            r_sticky <= 1'b0;
        end
    end

    assign estouro_sticky = r_sticky;

`ifdef REDUTOR_CONTADOR_EN
    logic [LARGURA_CONTADOR-1:0] r_contador;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_contador <= '0;
        end else if (limpar_status) begin
            r_contador <= '0;
        end else if (w_push && w_estouro && (r_contador != '1)) begin
            r_contador <= r_contador + 1'b1;
        end
    end

    assign contador_estouro = r_contador;
`endif

endmodule

// File: tb/tb_redutor_sinal.sv
// Bench for redutor_sinal: directed scenarios plus random traffic against a queue-based reference model.
module tb_redutor_sinal;

    logic        clk;
    logic        rst_n;
    logic        entrada_valida;
    logic        entrada_pronta;
    logic [31:0] palavra_entrada;
    logic        modo_saturar;
    logic        saida_valida;
    logic        saida_pronta;
    logic [15:0] palavra_saida;
    logic        saida_estourou;
    logic        estouro_sticky;
    logic        limpar_status;
`ifdef REDUTOR_CONTADOR_EN
    logic [7:0]  contador_estouro;
    int          m_cnt;
`endif

    int          n_testes;
    int          n_falhas;
    logic [16:0] q[$];
    logic        m_sticky;

    redutor_sinal dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .entrada_valida   (entrada_valida),
        .entrada_pronta   (entrada_pronta),
        .palavra_entrada  (palavra_entrada),
        .modo_saturar     (modo_saturar),
        .saida_valida     (saida_valida),
        .saida_pronta     (saida_pronta),
        .palavra_saida    (palavra_saida),
        .saida_estourou   (saida_estourou),
        .estouro_sticky   (estouro_sticky),
        .limpar_status    (limpar_status)
`ifdef REDUTOR_CONTADOR_EN
        ,
        .contador_estouro (contador_estouro)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_testes++;
        if (obs !== exp) begin
            n_falhas++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, 16-bit result} from the numeric value of the word.
    function automatic logic [16:0] modelo(input logic [31:0] x, input logic sat);
        longint v;
        v = longint'($signed(x));
        if (v >= -32768 && v <= 32767) return {1'b0, x[15:0]};
        if (!sat) return {1'b1, x[15:0]};
        return (v < 0) ? {1'b1, 16'h8000} : {1'b1, 16'h7FFF};
    endfunction

    task automatic conferir();
        chk("saida_valida", 32'(saida_valida), 32'(q.size() > 0));
        chk("entrada_pronta", 32'(entrada_pronta), 32'(q.size() < 2));
        if (q.size() > 0) begin
            chk("palavra_saida", 32'(palavra_saida), 32'(q[0][15:0]));
            chk("saida_estourou", 32'(saida_estourou), 32'(q[0][16]));
        end else begin
            chk("palavra_vazia", 32'(palavra_saida), 32'h0);
        end
        chk("sticky", 32'(estouro_sticky), 32'(m_sticky));
`ifdef REDUTOR_CONTADOR_EN
        chk("contador", 32'(contador_estouro), 32'(m_cnt));
`endif
    endtask

    task automatic passo(input logic v, input logic [31:0] x, input logic m,
                         input logic r, input logic clr);
        logic        aceita;
        logic        retira;
        logic [16:0] n;
        entrada_valida  = v;
        palavra_entrada = x;
        modo_saturar    = m;
        saida_pronta    = r;
        limpar_status   = clr;
        aceita = v && (q.size() < 2);
        retira = r && (q.size() > 0);
        n = modelo(x, m);
        @(posedge clk);
        if (retira) void'(q.pop_front());
        if (aceita) q.push_back(n);
        m_sticky = (m_sticky && !clr) || (aceita && n[16]);
`ifdef REDUTOR_CONTADOR_EN
        if (clr) m_cnt = 0;
        else if (aceita && n[16] && m_cnt < 255) m_cnt++;
`endif
        #1;
        conferir();
    endtask

    task automatic zerar_modelo();
        q.delete();
        m_sticky = 1'b0;
`ifdef REDUTOR_CONTADOR_EN
        m_cnt = 0;
`endif
    endtask

    function automatic logic [31:0] palavra_aleatoria();
        logic [31:0] bordas [4];
        logic [15:0] h;
        bordas[0] = 32'h00007FFF;
        bordas[1] = 32'h00008000;
        bordas[2] = 32'hFFFF7FFF;
        bordas[3] = 32'hFFFF8000;
        h = 16'($urandom);
        case ($urandom_range(0, 2))
            0:       return {{16{h[15]}}, h};
            1:       return $urandom;
            default: return bordas[$urandom_range(0, 3)];
        endcase
    endfunction

    initial begin
        n_testes        = 0;
        n_falhas        = 0;
        rst_n           = 1'b0;
        entrada_valida  = 1'b0;
        palavra_entrada = '0;
        modo_saturar    = 1'b0;
        saida_pronta    = 1'b0;
        limpar_status   = 1'b0;
        zerar_modelo();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        conferir();

        // In-range values.
        passo(1'b1, 32'h00001234, 1'b0, 1'b1, 1'b0);
        chk("in_range_1234", 32'(palavra_saida), 32'h1234);
        chk("in_range_ovf_a", 32'(saida_estourou), 32'h0);
        passo(1'b1, 32'hFFFF8000, 1'b0, 1'b1, 1'b0);
        chk("in_range_8000", 32'(palavra_saida), 32'h8000);
        chk("in_range_ovf_b", 32'(saida_estourou), 32'h0);

        // Saturation after a status clear.
        passo(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        passo(1'b1, 32'h00012345, 1'b1, 1'b1, 1'b0);
        chk("sat_pos", 32'(palavra_saida), 32'h7FFF);
        chk("sat_pos_ovf", 32'(saida_estourou), 32'h1);
        passo(1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0);
        chk("sat_neg", 32'(palavra_saida), 32'h8000);
        chk("sat_neg_ovf", 32'(saida_estourou), 32'h1);
        chk("sat_sticky", 32'(estouro_sticky), 32'h1);
`ifdef REDUTOR_CONTADOR_EN
        chk("sat_contador", 32'(contador_estouro), 32'h2);
`endif

        // Wrap.
        passo(1'b1, 32'h00018001, 1'b0, 1'b1, 1'b0);
        chk("wrap", 32'(palavra_saida), 32'h8001);
        chk("wrap_ovf", 32'(saida_estourou), 32'h1);
        passo(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Backpressure with three offered words.
        passo(1'b1, 32'h00000011, 1'b0, 1'b0, 1'b0);
        passo(1'b1, 32'h00000022, 1'b0, 1'b0, 1'b0);
        passo(1'b1, 32'h00000033, 1'b0, 1'b0, 1'b0);
        chk("bp_cheia", 32'(entrada_pronta), 32'h0);
        chk("bp_cabeca", 32'(palavra_saida), 32'h0011);
        passo(1'b1, 32'h00000033, 1'b0, 1'b0, 1'b0);
        chk("bp_estavel", 32'(palavra_saida), 32'h0011);
        passo(1'b1, 32'h00000033, 1'b0, 1'b1, 1'b0);
        chk("bp_pop", 32'(palavra_saida), 32'h0022);
        chk("bp_livre", 32'(entrada_pronta), 32'h1);
        passo(1'b1, 32'h00000033, 1'b0, 1'b0, 1'b0);
        chk("bp_terceira", 32'(entrada_pronta), 32'h0);
        passo(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("bp_ordem", 32'(palavra_saida), 32'h0033);
        passo(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            passo(1'($urandom), palavra_aleatoria(), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 15) == 0));
        end

        // Counter saturation, then clear together with an overflow.
        for (int i = 0; i < 300; i++) begin
            passo(1'b1, {16'($urandom_range(1, 32767)), 16'($urandom)}, 1'($urandom), 1'b1, 1'b0);
        end
`ifdef REDUTOR_CONTADOR_EN
        chk("cnt_saturado", 32'(contador_estouro), 32'hFF);
`endif
        passo(1'b1, 32'h7FFF0000, 1'b1, 1'b1, 1'b1);
        chk("clr_sticky", 32'(estouro_sticky), 32'h1);
`ifdef REDUTOR_CONTADOR_EN
        chk("clr_contador", 32'(contador_estouro), 32'h0);
`endif

        // Reset asserted while words are in flight.
        passo(1'b1, 32'h00040000, 1'b1, 1'b0, 1'b0);
        passo(1'b1, 32'h00000055, 1'b0, 1'b0, 1'b0);
        entrada_valida = 1'b1;
        #2;
        rst_n = 1'b0;
        zerar_modelo();
        #1;
        conferir();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_valida", 32'(saida_valida), 32'h0);
        chk("rst_pronta", 32'(entrada_pronta), 32'h1);
        chk("rst_sticky", 32'(estouro_sticky), 32'h0);
`ifdef REDUTOR_CONTADOR_EN
        chk("rst_contador", 32'(contador_estouro), 32'h0);
`endif
        passo(1'b1, 32'h00000077, 1'b0, 1'b1, 1'b0);
        passo(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule
